// File: rtl/pmem.sv
// pmem: byte-addressable single-port memory, valid/ready requests,
// in-order buffered responses with credit-limited outstanding requests.
module pmem #(
  parameter int    DATA_W      = 32,
  parameter int    DEPTH_BYTES = 4096,
  parameter int    READ_LAT    = 1,
  parameter string INIT_FILE   = "IMEM_MEMORY_IN.hex",
  parameter string DUMP_FILE   = "IMEM_MEMORY_OUT.hex"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int NB   = DATA_W / 8;
  localparam int FD   = READ_LAT + 1;
  localparam int AW   = $clog2(DEPTH_BYTES);
  localparam int PTRW = $clog2(FD);
  localparam int CW   = $clog2(FD + 1);

  logic [7:0] mem [DEPTH_BYTES];

  logic [AW-1:0]     idx;
  logic              acc;
  logic              ok;
  logic              pop;
  logic [DATA_W-1:0] rd;
  logic [DATA_W-1:0] res_d;
  logic              res_e;

  assign idx = req_addr[AW-1:0];
  assign acc = req_valid && req_ready;
  assign pop = rsp_valid && rsp_ready;
  // full 32-bit compare: addresses never wrap into the array
  assign ok  = ((req_addr % 32'(NB)) == 32'd0) &&
               (req_addr <= 32'(DEPTH_BYTES - NB));

  always_comb begin
    rd = '0;
    for (int i = 0; i < NB; i++)
      rd[8*i +: 8] = mem[idx + AW'(i)];
  end

  always_comb begin
    res_d = '1;
    res_e = 1'b1;
    if (ok) begin
      res_e = 1'b0;
      res_d = req_we ? '0 : rd;
    end
  end

  always_ff @(posedge clk) begin
    if (acc && req_we && ok) begin
      for (int i = 0; i < NB; i++)
        if (req_be[i]) mem[idx + AW'(i)] <= req_wdata[8*i +: 8];
    end
  end

  logic              push_v;
  logic [DATA_W-1:0] push_d;
  logic              push_e;

  // the accepting edge is the first pipeline stage
  if (READ_LAT == 1) begin : g_nopipe
    assign push_v = acc;
    assign push_d = res_d;
    assign push_e = res_e;
  end else begin : g_pipe
    logic [READ_LAT-2:0] v_q;
    logic [DATA_W-1:0]   d_q [READ_LAT-1];
    logic                e_q [READ_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= '0;
      end else begin
        v_q[0] <= acc;
        for (int i = 1; i < READ_LAT-1; i++) v_q[i] <= v_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      d_q[0] <= res_d;
      e_q[0] <= res_e;
      for (int i = 1; i < READ_LAT-1; i++) begin
        d_q[i] <= d_q[i-1];
        e_q[i] <= e_q[i-1];
      end
    end

    assign push_v = v_q[READ_LAT-2];
    assign push_d = d_q[READ_LAT-2];
    assign push_e = e_q[READ_LAT-2];
  end

  logic [DATA_W-1:0] fd_q [FD];
  logic              fe_q [FD];
  logic [PTRW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d, oc_q, oc_d;

  always_ff @(posedge clk) begin
    if (push_v) begin
      fd_q[wp_q] <= push_d;
      fe_q[wp_q] <= push_e;
    end
  end

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    oc_d  = oc_q;
    if (push_v) wp_d = (wp_q == PTRW'(FD-1)) ? '0 : wp_q + 1'b1;
    if (pop)    rp_d = (rp_q == PTRW'(FD-1)) ? '0 : rp_q + 1'b1;
    if (push_v && !pop) cnt_d = cnt_q + 1'b1;
    if (!push_v && pop) cnt_d = cnt_q - 1'b1;
    if (acc && !pop)    oc_d  = oc_q + 1'b1;
    if (!acc && pop)    oc_d  = oc_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      oc_q  <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      oc_q  <= oc_d;
    end
  end

  assign req_ready = !rst && (oc_q < CW'(FD));
  assign rsp_valid = (cnt_q != '0);
  assign rsp_rdata = rsp_valid ? fd_q[rp_q] : '0;
  assign rsp_err   = rsp_valid && fe_q[rp_q];

endmodule
